rect_painter: RTL

RECT_PAINTER -- requirements
Module: rect_painter

---
 rtl/rect_painter_if.sv | 36 +++
 rtl/rect_painter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rect_painter_if.sv
// ============================================================================
// Module   : rect_painter_if
// Function : Pixel stream, rectangle bounds and drawn-pixel result bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rect_painter_if #(
  parameter int COLOR_W = 8
);
  logic               frame_start;
  logic               de;
  logic [10:0]        x;
  logic [10:0]        y;
  logic [10:0]        start_h;
  logic [10:0]        end_h;
  logic [10:0]        start_w;
  logic [10:0]        end_w;
  logic [COLOR_W-1:0] color;
  logic               pix_on;
  logic [COLOR_W-1:0] pix_color;
  logic               out_de;
  logic [18:0]        last_count;

  modport master (
    output frame_start, de, x, y, start_h, end_h, start_w, end_w, color,
    input  pix_on, pix_color, out_de, last_count
  );

  modport slave (
    input  frame_start, de, x, y, start_h, end_h, start_w, end_w, color,
    output pix_on, pix_color, out_de, last_count
  );
endinterface

`default_nettype wire

// File: rtl/rect_painter.sv
// ============================================================================
// Module   : rect_painter
// Function : Two-stage raster rectangle overlay with per-frame pixel count.
//            RECT_PAINTER_BORDER_EN draws only the 1-pixel outline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rect_painter #(
  parameter int WIDTH   = 639,
  parameter int HEIGHT  = 479,
  parameter int COLOR_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rect_painter_if.slave bus
);

  localparam logic [10:0] c_X_MAX   = 11'(WIDTH);
  localparam logic [10:0] c_Y_MAX   = 11'(HEIGHT);
  localparam logic [18:0] c_CNT_MAX = '1;

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [10:0]        r_sh_start_h;
  logic [10:0]        r_sh_end_h;
  logic [10:0]        r_sh_start_w;
  logic [10:0]        r_sh_end_w;
  logic [COLOR_W-1:0] r_sh_color;

  logic               r_s1_de;
  logic               r_s1_act;
  logic               r_s1_ge_h;
  logic               r_s1_le_h;
  logic               r_s1_ge_w;
  logic               r_s1_le_w;
  logic               r_s1_edge;
  logic [COLOR_W-1:0] r_s1_color;

  logic               r_pix_on;
  logic [COLOR_W-1:0] r_pix_color;
  logic               r_out_de;
  logic [18:0]        r_cnt;
  logic [18:0]        r_last_count;

  logic               w_in_range;
  logic               w_edge;
  logic               w_hit;
  logic [18:0]        w_cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= WAIT_FRAME;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_FRAME: if (bus.frame_start) w_state_nxt = ACTIVE;
      ACTIVE:     w_state_nxt = ACTIVE;
      default:    w_state_nxt = WAIT_FRAME;
    endcase
  end

  // Shadows only move on frame_start, so the pixel in that same cycle still
  // compares against the previous frame's bounds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_start_h <= '0;
      r_sh_end_h   <= '0;
      r_sh_start_w <= '0;
      r_sh_end_w   <= '0;
      r_sh_color   <= '0;
    end else if (bus.frame_start) begin
      r_sh_start_h <= bus.start_h;
      r_sh_end_h   <= bus.end_h;
      r_sh_start_w <= bus.start_w;
      r_sh_end_w   <= bus.end_w;
      r_sh_color   <= bus.color;
    end
  end

  assign w_in_range = (bus.x <= c_X_MAX) && (bus.y <= c_Y_MAX);

`ifdef RECT_PAINTER_BORDER_EN
  assign w_edge = (bus.y == r_sh_start_h) || (bus.y == r_sh_end_h) ||
                  (bus.x == r_sh_start_w) || (bus.x == r_sh_end_w);
`else
  assign w_edge = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_de    <= 1'b0;
      r_s1_act   <= 1'b0;
      r_s1_ge_h  <= 1'b0;
      r_s1_le_h  <= 1'b0;
      r_s1_ge_w  <= 1'b0;
      r_s1_le_w  <= 1'b0;
      r_s1_edge  <= 1'b0;
      r_s1_color <= '0;
    end else begin
      r_s1_de    <= bus.de;
      r_s1_act   <= (r_state == ACTIVE) && w_in_range;
      r_s1_ge_h  <= bus.y >= r_sh_start_h;
      r_s1_le_h  <= bus.y <= r_sh_end_h;
      r_s1_ge_w  <= bus.x >= r_sh_start_w;
      r_s1_le_w  <= bus.x <= r_sh_end_w;
      r_s1_edge  <= w_edge;
      r_s1_color <= r_sh_color;
    end
  end

  assign w_hit = r_s1_de & r_s1_act & r_s1_ge_h & r_s1_le_h &
                 r_s1_ge_w & r_s1_le_w & r_s1_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pix_on    <= 1'b0;
      r_pix_color <= '0;
      r_out_de    <= 1'b0;
    end else begin
      r_pix_on    <= w_hit;
      r_pix_color <= w_hit ? r_s1_color : '0;
      r_out_de    <= r_s1_de;
    end
  end

  // The count snapshot includes the pixel leaving stage 2 on the frame_start edge.
  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 19'(r_pix_on);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_last_count <= '0;
    end else if (bus.frame_start) begin
      r_cnt <= '0;
      if (r_state == ACTIVE) r_last_count <= w_cnt_inc;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign bus.pix_on     = r_pix_on;
  assign bus.pix_color  = r_pix_color;
  assign bus.out_de     = r_out_de;
  assign bus.last_count = r_last_count;

endmodule

`default_nettype wire
